parking_sensor_gen: RTL and testbench

Sensor-pattern transmitter for the parking-lot occupancy counter. It accepts one traversal request per valid/ready handshake and drives the outer/inner photo-sensor lines with the matching waveform: car enter, car exit, pedestrian enter or pedestrian exit. It serves as the bench/emulation source that feeds the counter FSM, and as a sensor emulator on the demo board.

---
 rtl/parking_sensor_gen.sv | 159 +++++++++++++++
 tb/tb_parking_sensor_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/parking_sensor_gen.sv
// Photo-sensor waveform emitter: one traversal per valid/ready handshake, PH1 visible the cycle after accept.
// req_ready is high only in IDLE; requests offered while busy are neither accepted nor queued.
module parking_sensor_gen #(
  parameter int DWELL = 1,
  parameter int GAP   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_dir,
  input  logic             req_ped,
  output logic             outer,
  output logic             inner,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] enter_cnt,
  output logic [CNT_W-1:0] exit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PH1  = 3'd1,
    S_PH2  = 3'd2,
    S_PH3  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [7:0] DWELL_LD = 8'(DWELL - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP - 1);

  state_t           state_q, state_d;
  logic [7:0]       dwell_q, dwell_d;
  logic             dir_q, dir_d;
  logic             ped_q, ped_d;
  logic             outer_q, outer_d;
  logic             inner_q, inner_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] enter_q, enter_d;
  logic [CNT_W-1:0] exit_q, exit_d;
  logic             last;

  assign req_ready = (state_q == S_IDLE);
  assign last      = (dwell_q == 8'd0);

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    dir_d   = dir_q;
    ped_d   = ped_q;
    done_d  = 1'b0;
    enter_d = enter_q;
    exit_d  = exit_q;
    outer_d = 1'b0;
    inner_d = 1'b0;
    if (state_q != S_IDLE && !last) begin
      dwell_d = dwell_q - 8'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_PH1;
          dwell_d = DWELL_LD;
          dir_d   = req_dir;
          ped_d   = req_ped;
        end
      end
      S_PH1: begin
        if (last) begin
          // Pedestrians never block both beams, so they skip the overlap phase.
          state_d = ped_q ? S_PH3 : S_PH2;
          dwell_d = DWELL_LD;
        end
      end
      S_PH2: begin
        if (last) begin
          state_d = S_PH3;
          dwell_d = DWELL_LD;
        end
      end
      S_PH3: begin
        if (last) begin
          state_d = S_GAP;
          dwell_d = GAP_LD;
        end
      end
      S_GAP: begin
        if (last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!ped_q) begin
            if (dir_q) exit_d = exit_q + 1'b1;
            else       enter_d = enter_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        dwell_d = 8'd0;
      end
    endcase
    // Decode from the next state so the registered lines line up with the state register.
    case (state_d)
      S_PH1: begin
        outer_d = ~dir_d;
        inner_d = dir_d;
      end
      S_PH2: begin
        outer_d = 1'b1;
        inner_d = 1'b1;
      end
      S_PH3: begin
        outer_d = dir_d;
        inner_d = ~dir_d;
      end
      default: begin
        outer_d = 1'b0;
        inner_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dwell_q <= 8'd0;
      dir_q   <= 1'b0;
      ped_q   <= 1'b0;
      outer_q <= 1'b0;
      inner_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      enter_q <= '0;
      exit_q  <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      dir_q   <= dir_d;
      ped_q   <= ped_d;
      outer_q <= outer_d;
      inner_q <= inner_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
    end
  end

  assign outer     = outer_q;
  assign inner     = inner_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign enter_cnt = enter_q;
  assign exit_cnt  = exit_q;

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Directed bench: instance A (DWELL=1, GAP=1, CNT_W=8) and instance B (DWELL=3, GAP=2, CNT_W=4).
module tb_parking_sensor_gen;

  logic clk = 1'b0;
  logic reset;
  logic sel;
  logic req_valid, req_dir, req_ped;

  logic       rdy_a, outer_a, inner_a, busy_a, done_a;
  logic [7:0] en_a, ex_a;
  logic       rdy_b, outer_b, inner_b, busy_b, done_b;
  logic [3:0] en_b, ex_b;

  logic       rdy_m, outer_m, inner_m, busy_m, done_m;
  logic [7:0] en_m, ex_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  parking_sensor_gen #(.DWELL(1), .GAP(1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy_a),
    .req_dir(req_dir), .req_ped(req_ped), .outer(outer_a), .inner(inner_a),
    .busy(busy_a), .done(done_a), .enter_cnt(en_a), .exit_cnt(ex_a)
  );

  parking_sensor_gen #(.DWELL(3), .GAP(2), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy_b),
    .req_dir(req_dir), .req_ped(req_ped), .outer(outer_b), .inner(inner_b),
    .busy(busy_b), .done(done_b), .enter_cnt(en_b), .exit_cnt(ex_b)
  );

  assign rdy_m   = sel ? rdy_b   : rdy_a;
  assign outer_m = sel ? outer_b : outer_a;
  assign inner_m = sel ? inner_b : inner_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign en_m    = sel ? {4'b0, en_b} : en_a;
  assign ex_m    = sel ? {4'b0, ex_b} : ex_a;

  typedef struct {
    logic       dir;
    logic       ped;
    int         nph;
    logic [7:0] wave;
    logic [7:0] exp_en;
    logic [7:0] exp_ex;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One traversal; wave holds nph {outer,inner} pairs MSB-first, the last pair being the gap.
  // A conflicting request is offered throughout the busy period and must be ignored.
  task automatic run_txn(input logic dir, input logic ped, input int nph, input logic [7:0] wave,
                         input int dwell, input int gap, input logic [7:0] en, input logic [7:0] ex);
    int len;
    @(negedge clk);
    chk("ready_before_accept", rdy_m, 1);
    req_valid = 1'b1;
    req_dir   = dir;
    req_ped   = ped;
    @(negedge clk);
    req_dir = ~dir;
    req_ped = ~ped;
    for (int p = 0; p < nph; p++) begin
      len = (p == nph - 1) ? gap : dwell;
      for (int c = 0; c < len; c++) begin
        if (!(p == 0 && c == 0)) @(negedge clk);
        req_valid = !(p == nph - 1 && c == len - 1);
        chk("wave", {outer_m, inner_m}, wave[7-2*p -: 2]);
        chk("busy_active", busy_m, 1);
        chk("ready_busy", rdy_m, 0);
        chk("done_early", done_m, 0);
      end
    end
    @(negedge clk);
    chk("done_pulse", done_m, 1);
    chk("ready_done", rdy_m, 1);
    chk("wave_idle", {outer_m, inner_m}, 2'b00);
    chk("enter_cnt", en_m, en);
    chk("exit_cnt", ex_m, ex);
    @(negedge clk);
    chk("done_clear", done_m, 0);
    chk("busy_after", busy_m, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] pat [5];
    vecs[0] = '{dir: 1'b0, ped: 1'b0, nph: 4, wave: 8'b10_11_01_00, exp_en: 8'd1, exp_ex: 8'd0};
    vecs[1] = '{dir: 1'b1, ped: 1'b0, nph: 4, wave: 8'b01_11_10_00, exp_en: 8'd1, exp_ex: 8'd1};
    vecs[2] = '{dir: 1'b0, ped: 1'b1, nph: 3, wave: 8'b10_01_00_00, exp_en: 8'd1, exp_ex: 8'd1};
    vecs[3] = '{dir: 1'b1, ped: 1'b1, nph: 3, wave: 8'b01_10_00_00, exp_en: 8'd1, exp_ex: 8'd1};
    vecs[4] = '{dir: 1'b0, ped: 1'b0, nph: 4, wave: 8'b10_11_01_00, exp_en: 8'd2, exp_ex: 8'd1};
    pat[0] = 2'b10; pat[1] = 2'b11; pat[2] = 2'b01; pat[3] = 2'b00; pat[4] = 2'b00;

    sel = 1'b0; req_valid = 1'b0; req_dir = 1'b0; req_ped = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_outer", outer_m, 0);
      chk("rst_inner", inner_m, 0);
      chk("rst_busy", busy_m, 0);
      chk("rst_done", done_m, 0);
      chk("rst_enter", en_m, 0);
      chk("rst_exit", ex_m, 0);
      chk("rst_ready", rdy_m, 1);
    end
    sel = 1'b0;

    // Table: car enter/exit, pedestrian enter/exit, car enter.
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].dir, vecs[i].ped, vecs[i].nph, vecs[i].wave, 1, 1, vecs[i].exp_en, vecs[i].exp_ex);
    end

    // Reset during PH2 of a car enter.
    @(negedge clk);
    req_valid = 1'b1; req_dir = 1'b0; req_ped = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mr_ph1", {outer_m, inner_m}, 2'b10);
    @(negedge clk);
    chk("mr_ph2", {outer_m, inner_m}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_lines", {outer_m, inner_m}, 2'b00);
    chk("mr_busy", busy_m, 0);
    chk("mr_done", done_m, 0);
    chk("mr_enter", en_m, 0);
    chk("mr_exit", ex_m, 0);
    chk("mr_ready", rdy_m, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mr_no_done", {done_m, busy_m}, 2'b00);
    end
    run_txn(1'b0, 1'b0, 4, 8'b10_11_01_00, 1, 1, 8'd1, 8'd0);

    // 31 back-to-back car enters with req_valid held high.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    req_valid = 1'b1; req_dir = 1'b0; req_ped = 1'b0;
    for (int c = 1; c <= 155; c++) begin
      @(negedge clk);
      if (c == 151) req_valid = 1'b0;
      chk("b2b_wave", {outer_m, inner_m, done_m}, {pat[(c-1)%5], ((c-1)%5 == 4) ? 1'b1 : 1'b0});
      if ((c-1)%5 == 4) chk("b2b_enter", en_m, c/5);
    end
    @(negedge clk);
    chk("b2b_end", {busy_m, done_m, rdy_m}, 3'b001);

    // Instance B: long dwell/gap waveform, then wrap of the 4-bit counter.
    sel = 1'b1;
    run_txn(1'b0, 1'b0, 4, 8'b10_11_01_00, 3, 2, 8'd1, 8'd0);
    for (int k = 1; k <= 16; k++) begin
      run_txn(1'b0, 1'b0, 4, 8'b10_11_01_00, 3, 2, 8'((1 + k) % 16), 8'd0);
    end
    chk("wrap_final", en_m, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
